// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch stage.
// Physical addressing is real-mode style: segment shifted left 4 plus offset.
package prefetch_pkg;

  localparam int ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pf_state_e;

  // Carry out of bit 19 is dropped, so addresses wrap at 1 MiB.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] cs,
                                                   input logic [15:0] ip);
    return {cs, 4'h0} + {4'h0, ip};
  endfunction

endpackage

// File: rtl/prefetch_unit_byte_fifo.sv
// Byte FIFO between the prefetch FSM and the opcode/immediate readers.
// Registered read port (no show-ahead); flush wins over push and pop.
module byte_fifo #(
  parameter  int DEPTH = 6,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [7:0]       rd_data,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [7:0]       rd_data_q;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_wr = wr_en && !flush;
  assign do_rd = rd_en && !flush && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch: fetches 16-bit words at CS:IP, splits them into bytes
// in address order and queues them; load_new_ip flushes and restarts the stream.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter  int DEPTH = 6,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_new_ip,
  input  logic [15:0]       new_cs,
  input  logic [15:0]       new_ip,
  output logic              mem_access,
  input  logic              mem_ack,
  output logic [ADDR_W-2:0] mem_address,
  input  logic [15:0]       mem_data,
  input  logic              fifo_rd_en,
  output logic [7:0]        fifo_rd_data,
  output logic              fifo_empty
);

  // Handshake: mem_access is raised with a stable mem_address and held until
  // the cycle mem_ack is seen; mem_data is sampled only in that ack cycle.

  pf_state_e         state_q;
  logic [15:0]       cs_q;
  logic [15:0]       fetch_ip_q;
  logic              abort_q;
  logic              hold_valid_q;
  logic [7:0]        hold_byte_q;
  logic              mem_access_q;
  logic [ADDR_W-2:0] mem_address_q;

  logic              fifo_wr_en;
  logic [7:0]        fifo_wr_data;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_full;
  logic [PTR_W+1:0]  used_slots;
  logic              can_req;
  logic [ADDR_W-2:0] req_word;
  logic              unused_phys_lsb;

  assign {req_word, unused_phys_lsb} = phys_addr(cs_q, fetch_ip_q);

  // A word may produce two bytes, so only request with two free slots.
  assign used_slots = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, hold_valid_q};
  assign can_req    = (used_slots <= (PTR_W+2)'(DEPTH - 2));

  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    unique case (state_q)
      REQ: begin
        if (mem_ack && !abort_q && !load_new_ip) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = fetch_ip_q[0] ? mem_data[15:8] : mem_data[7:0];
        end
      end
      HOLD: begin
        if (hold_valid_q && !load_new_ip) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = hold_byte_q;
        end
      end
      default: begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cs_q          <= 16'h0000;
      fetch_ip_q    <= 16'h0000;
      abort_q       <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_byte_q   <= 8'h00;
      mem_access_q  <= 1'b0;
      mem_address_q <= '0;
    end else begin
      if (load_new_ip) begin
        cs_q         <= new_cs;
        fetch_ip_q   <= new_ip;
        hold_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (can_req && !load_new_ip) begin
            state_q       <= REQ;
            mem_access_q  <= 1'b1;
            mem_address_q <= req_word;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_access_q <= 1'b0;
            abort_q      <= 1'b0;
            state_q      <= IDLE;
            if (!abort_q && !load_new_ip) begin
              if (!fetch_ip_q[0]) begin
                hold_byte_q  <= mem_data[15:8];
                hold_valid_q <= 1'b1;
                fetch_ip_q   <= fetch_ip_q + 16'd2;
                state_q      <= HOLD;
              end else begin
                fetch_ip_q <= fetch_ip_q + 16'd1;
              end
            end
          end else if (load_new_ip) begin
            // The bus cycle cannot be cancelled; its data is dropped on ack.
            abort_q <= 1'b1;
          end
        end
        HOLD: begin
          hold_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .flush   (load_new_ip),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign mem_access  = mem_access_q;
  assign mem_address = mem_address_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: each step drives inputs at posedge+1 and
// checks outputs at that same point against hand-computed values.
module tb_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_new_ip;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        mem_access;
  logic        mem_ack;
  logic [18:0] mem_address;
  logic [15:0] mem_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prefetch_unit #(.DEPTH(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_new_ip  (load_new_ip),
    .new_cs       (new_cs),
    .new_ip       (new_ip),
    .mem_access   (mem_access),
    .mem_ack      (mem_ack),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [15:0] d);
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    check(tag, {24'h0, fifo_rd_data}, {24'h0, exp});
  endtask

  // Reset (possibly mid-request), then load cs:ip and expect the first request.
  task automatic restart(input logic [15:0] cs, input logic [15:0] ip, input logic [18:0] exp_addr);
    reset = 1'b1;
    #1;
    check("rst_access", {31'h0, mem_access}, 32'h0);
    check("rst_empty", {31'h0, fifo_empty}, 32'h1);
    check("rst_rd_data", {24'h0, fifo_rd_data}, 32'h0);
    tick();
    reset       = 1'b0;
    load_new_ip = 1'b1;
    new_cs      = cs;
    new_ip      = ip;
    tick();
    load_new_ip = 1'b0;
    check("load_no_req", {31'h0, mem_access}, 32'h0);
    tick();
    check("req_access", {31'h0, mem_access}, 32'h1);
    check("req_addr", {13'h0, mem_address}, {13'h0, exp_addr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    load_new_ip = 1'b0;
    new_cs      = 16'h0000;
    new_ip      = 16'h0000;
    mem_ack     = 1'b0;
    mem_data    = 16'h0000;
    fifo_rd_en  = 1'b0;
    tick();
    tick();
    check("reset_addr", {13'h0, mem_address}, 32'h0);

    // Step 1: even ip, both bytes in address order, next word follows.
    restart(16'hF000, 16'hFFF0, 19'h7FFF8);
    check("t1_empty_before", {31'h0, fifo_empty}, 32'h1);
    ack(16'h1234);
    check("t1_access_drop", {31'h0, mem_access}, 32'h0);
    check("t1_not_empty", {31'h0, fifo_empty}, 32'h0);
    tick();
    check("t1_idle_gap", {31'h0, mem_access}, 32'h0);
    tick();
    check("t1_next_access", {31'h0, mem_access}, 32'h1);
    check("t1_next_addr", {13'h0, mem_address}, 32'h7FFF9);
    pop("t1_pop0", 8'h34);
    pop("t1_pop1", 8'h12);
    check("t1_empty_after", {31'h0, fifo_empty}, 32'h1);

    // Step 2: odd ip takes only the high byte.
    restart(16'h0000, 16'h0001, 19'h00000);
    ack(16'hABCD);
    check("t2_access_drop", {31'h0, mem_access}, 32'h0);
    check("t2_not_empty", {31'h0, fifo_empty}, 32'h0);
    tick();
    check("t2_next_addr", {13'h0, mem_address}, 32'h00001);
    check("t2_next_access", {31'h0, mem_access}, 32'h1);
    pop("t2_pop0", 8'hAB);
    check("t2_empty_after", {31'h0, fifo_empty}, 32'h1);

    // Step 3: fill six slots with three words, stall, then resume after two pops.
    restart(16'h0000, 16'h0100, 19'h00080);
    for (int w = 0; w < 3; w++) begin
      check($sformatf("t3_access_w%0d", w), {31'h0, mem_access}, 32'h1);
      check($sformatf("t3_addr_w%0d", w), {13'h0, mem_address}, 32'h80 + 32'(w));
      ack({8'(2*w + 1), 8'(2*w)});
      tick();
      tick();
    end
    check("t3_stall0", {31'h0, mem_access}, 32'h0);
    tick();
    tick();
    tick();
    check("t3_stall1", {31'h0, mem_access}, 32'h0);
    pop("t3_pop0", 8'h00);
    pop("t3_pop1", 8'h01);
    tick();
    check("t3_resume_access", {31'h0, mem_access}, 32'h1);
    check("t3_resume_addr", {13'h0, mem_address}, 32'h83);
    pop("t3_pop2", 8'h02);
    pop("t3_pop3", 8'h03);
    pop("t3_pop4", 8'h04);
    pop("t3_pop5", 8'h05);
    check("t3_empty_after", {31'h0, fifo_empty}, 32'h1);

    // Step 4: ip wraps inside the segment, cs unchanged.
    restart(16'h1000, 16'hFFFE, 19'h0FFFF);
    ack(16'h5566);
    tick();
    tick();
    check("t4_wrap_access", {31'h0, mem_access}, 32'h1);
    check("t4_wrap_addr", {13'h0, mem_address}, 32'h08000);
    pop("t4_pop0", 8'h66);
    pop("t4_pop1", 8'h55);

    // Step 5: branch during an outstanding request with a delayed ack.
    restart(16'h0000, 16'h0400, 19'h00200);
    load_new_ip = 1'b1;
    new_cs      = 16'h0000;
    new_ip      = 16'h0100;
    tick();
    load_new_ip = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t5_held_c%0d", c), {31'h0, mem_access}, 32'h1);
      check($sformatf("t5_empty_c%0d", c), {31'h0, fifo_empty}, 32'h1);
      if (c < 2) tick();
    end
    ack(16'hDEAD);
    check("t5_access_drop", {31'h0, mem_access}, 32'h0);
    check("t5_discarded", {31'h0, fifo_empty}, 32'h1);
    tick();
    check("t5_new_access", {31'h0, mem_access}, 32'h1);
    check("t5_new_addr", {13'h0, mem_address}, 32'h00080);
    check("t5_still_empty", {31'h0, fifo_empty}, 32'h1);

    // Step 6: pop and branch together with four bytes queued.
    restart(16'h0000, 16'h0300, 19'h00180);
    ack(16'hA1A0);
    tick();
    tick();
    check("t6_addr1", {13'h0, mem_address}, 32'h00181);
    ack(16'hA3A2);
    tick();
    tick();
    check("t6_addr2", {13'h0, mem_address}, 32'h00182);
    check("t6_queued", {31'h0, fifo_empty}, 32'h0);
    fifo_rd_en  = 1'b1;
    load_new_ip = 1'b1;
    new_cs      = 16'h0000;
    new_ip      = 16'h0500;
    tick();
    fifo_rd_en  = 1'b0;
    load_new_ip = 1'b0;
    check("t6_flushed", {31'h0, fifo_empty}, 32'h1);
    check("t6_rd_data_held", {24'h0, fifo_rd_data}, 32'h0);
    check("t6_abort_held", {31'h0, mem_access}, 32'h1);
    pop("t6_pop_empty", 8'h00);
    check("t6_still_empty", {31'h0, fifo_empty}, 32'h1);
    ack(16'hBEEF);
    check("t6_discarded", {31'h0, fifo_empty}, 32'h1);
    tick();
    check("t6_new_addr", {13'h0, mem_address}, 32'h00280);
    ack(16'h7170);
    check("t6_fresh_byte", {31'h0, fifo_empty}, 32'h0);
    pop("t6_pop0", 8'h70);
    pop("t6_pop1", 8'h71);
    check("t6_empty_end", {31'h0, fifo_empty}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_unit.md
Name: prefetch_unit

Overview:
Instruction prefetch stage feeding the immediate/opcode readers through an internal byte FIFO.
- Computes the physical fetch address from CS:IP and issues 16-bit word reads on the instruction memory port.
- Splits each returned word into bytes and pushes them, in address order, into a DEPTH-byte FIFO.
- Flushes the FIFO and restarts from a new CS:IP whenever a branch loads a new IP.

Parameters:
DEPTH, 6, byte FIFO capacity; legal values 4..16.
PTR_W, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
load_new_ip  in  1  single-cycle pulse: flush and restart at new_cs:new_ip
new_cs  in  16  new code segment
new_ip  in  16  new instruction pointer
mem_access  out  1  instruction read request, held until mem_ack
mem_ack  in  1  read complete; mem_data valid this cycle
mem_address  out  19  word address (physical[19:1])
mem_data  in  16  read data, little-endian
fifo_rd_en  in  1  pop one byte
fifo_rd_data  out  8  byte popped, registered; valid the cycle after fifo_rd_en
fifo_empty  out  1  no byte available

Behaviour:
- Reset (async): mem_access=0, mem_address=0, fifo_rd_data=0, fifo_empty=1, cs=0, fetch_ip=0, FIFO count=0, state IDLE, abort=0.
- Physical address = ({cs,4'h0} + {4'h0,fetch_ip}) mod 2^20; mem_address = phys[19:1].
- fetch_ip is 16 bits and wraps 0xFFFF->0x0000 within the segment; cs never changes except on load_new_ip.
- FSM states:
  - IDLE: go to REQ when free slots (DEPTH - count - hold_valid) >= 2 and load_new_ip=0. mem_access rises in the cycle REQ is entered; mem_address is stable for the whole request.
  - REQ: hold mem_access until mem_ack.
    - On ack with abort=0 and fetch_ip even: write mem_data[7:0] at this edge; latch mem_data[15:8] into hold (hold_valid=1); fetch_ip += 2.
    - On ack with abort=0 and fetch_ip odd: write only mem_data[15:8]; fetch_ip += 1.
    - Always go to IDLE (or HOLD if hold_valid) on ack.
  - HOLD: write the hold byte into the FIFO this edge; clear hold_valid; go to IDLE. A new request may be issued the following cycle.
- mem_access deasserts in the cycle after ack; a back-to-back request needs at least 1 idle cycle.
- FIFO: show-ahead is not used. On fifo_rd_en with fifo_empty=0, fifo_rd_data takes the head byte at the next edge. fifo_rd_en while empty is ignored (no pointer change, fifo_rd_data held).
- Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.
- The free-slot rule guarantees no overflow. Pushing while full is a design error; add an assertion.
- load_new_ip:
  - At the next edge: FIFO pointers and count cleared, hold_valid cleared, cs<=new_cs, fetch_ip<=new_ip, fifo_empty=1.
  - Overrides a simultaneous fifo_rd_en and push; fifo_rd_data keeps its old value.
  - If in REQ with ack not yet seen: mem_access stays high until mem_ack (no bus abort). abort=1 and the returned data is discarded. abort clears on that ack; the FSM then goes to IDLE and fetches from the new address.
  - If mem_ack coincides with load_new_ip: data discarded; no abort needed.
  - A second load_new_ip while aborting just replaces cs/fetch_ip.
- Reset mid-request: mem_access drops immediately; the memory side must tolerate this.

Decomposition:
- Package prefetch_pkg:
  - FSM state enum (IDLE, REQ, HOLD).
  - Function phys_addr(cs, ip) returning 20 bits.
  - Constant ADDR_W=20.
- Sub-module byte_fifo (DEPTH parameter): wr_en/wr_data, rd_en/rd_data (registered), flush, count, empty, full. The FSM stays in prefetch_unit.

Test Plan:
1. Reset, load_new_ip cs=0xF000 ip=0xFFF0 -> mem_address=0x7FFF8. Ack with mem_data=0x1234 -> two pops return 0x34 then 0x12. Next request at 0x7FFF9.
2. cs=0x0000 ip=0x0001 -> mem_address=0x00000. Ack with 0xABCD -> only 0xAB enters the FIFO. Next mem_address=0x00001; fetch_ip=0x0002.
3. DEPTH=6, ack every request, never pop -> exactly 3 words accepted (count=6). mem_access then stays low. One pop of 2 bytes -> one further request.
4. cs=0x1000 ip=0xFFFE -> first address phys 0x1FFFE (word 0xFFFF). ip wraps to 0x0000 -> next phys 0x10000 (word 0x8000).
5. load_new_ip (ip=0x0100) during REQ with ack delayed 3 cycles -> mem_access stays high until ack; returned word never appears in the FIFO. Next request at phys 0x00100 (cs=0); fifo_empty=1 throughout.
6. fifo_rd_en and load_new_ip in the same cycle with the FIFO holding 4 bytes -> fifo_empty=1 next cycle; fifo_rd_data unchanged; no stale byte is ever popped.
